// File: rtl/op_issuer.sv
// op_issuer: host-side initiator that sequences command words onto the
// matrix controller's operation/enable/in_data port and collects read pages.
module op_issuer #(
    parameter int unsigned PAGE_WORDS = 64,
    parameter int unsigned MM_CYCLES  = 80,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_word,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        ctl_enable,
    output logic [31:0] ctl_operation,
    output logic [31:0] ctl_in_data,
    input  logic [31:0] ctl_out_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned RD_SPAN = PAGE_WORDS + RD_LAT;
    localparam int unsigned CNT_MAX = (RD_SPAN > MM_CYCLES) ? RD_SPAN : MM_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned MM_LAST = MM_CYCLES - 1;
    localparam int unsigned WR_LAST = PAGE_WORDS - 1;
    localparam int unsigned RD_LAST = RD_SPAN - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MM    = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   cmd_q;
    logic          err_q;

    // Shared increment for the per-command word / cycle counter
    assign cnt_d = cnt_q + CW'(1);

    // Command sequencer: latch the word in IDLE, count cycles or handshakes, always pass through GAP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q <= cmd_word;
                        cnt_q <= '0;
                        case (cmd_word[3:0])
                            4'd0:    state_q <= S_GAP;
                            4'd1:    state_q <= S_MM;
                            4'd2:    state_q <= S_WRITE;
                            4'd3:    state_q <= S_READ;
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= S_GAP;
                            end
                        endcase
                    end
                end
                S_MM: begin
                    if (cnt_q == CW'(MM_LAST)) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        if (cnt_q == CW'(WR_LAST)) begin
                            cnt_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        if (cnt_q == CW'(RD_LAST)) begin
                            cnt_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_GAP: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Port drive decoded from the state register; enable follows the host handshake while streaming
    always_comb begin
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        ctl_enable    = 1'b0;
        ctl_operation = '0;
        ctl_in_data   = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready  = reset;
                ctl_enable = reset;
            end
            S_MM: begin
                ctl_operation = cmd_q;
                ctl_enable    = reset;
            end
            S_WRITE: begin
                ctl_operation = cmd_q;
                wr_ready      = 1'b1;
                ctl_enable    = reset & wr_valid;
                ctl_in_data   = wr_data;
            end
            S_READ: begin
                ctl_operation = cmd_q;
                ctl_enable    = reset & rd_ready;
                rd_valid      = rd_ready && (cnt_q >= CW'(RD_LAT));
            end
            S_GAP: begin
                ctl_enable = reset;
            end
            default: begin
                ctl_enable = 1'b0;
            end
        endcase
    end

    assign rd_data = ctl_out_data;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_GAP);
    assign err     = err_q;

endmodule

// File: tb/tb_op_issuer.sv
// Self-checking bench for op_issuer: directed table, reset/back-to-back sequences, random commands.
module tb_op_issuer;

    localparam int unsigned PAGE_WORDS = 64;
    localparam int unsigned MM_CYCLES  = 80;
    localparam int unsigned RD_LAT     = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_word = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        ctl_enable;
    logic [31:0] ctl_operation;
    logic [31:0] ctl_in_data;
    logic [31:0] ctl_out_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Controller stub: out_data is the number of enabled opcode-3 cycles so far, xor a per-test salt
    logic [31:0] rd_cnt;
    logic [31:0] salt = '0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset)                                           rd_cnt <= '0;
        else if (ctl_enable && (ctl_operation[3:0] == 4'd3)) rd_cnt <= rd_cnt + 32'd1;
        else if (ctl_operation == 32'd0)                      rd_cnt <= '0;
    end

    assign ctl_out_data = rd_cnt ^ salt;

    op_issuer #(
        .PAGE_WORDS(PAGE_WORDS),
        .MM_CYCLES (MM_CYCLES),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_word     (cmd_word),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .ctl_enable   (ctl_enable),
        .ctl_operation(ctl_operation),
        .ctl_in_data  (ctl_in_data),
        .ctl_out_data (ctl_out_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command from IDLE and judge the whole transaction against the command's rules.
    // mode: 0 continuous, 1 low every 4th cycle (write data 0..N-1), 2 random, 3 alternating.
    task automatic run_cmd(input logic [31:0] w, input int mode, input logic [31:0] first_op,
                           input logic exp_err);
        logic [3:0]  opc;
        logic [31:0] wdata;
        logic        v;
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int done_n, hs, last_hs, en_rd, last_en, mm_en, bad_op, mirror_bad, words, seq_bad, exp_done;
        opc = w[3:0];
        done_n = 0; hs = 0; last_hs = 0; en_rd = 0; last_en = 0; mm_en = 0;
        bad_op = 0; mirror_bad = 0; words = 0; seq_bad = 0;
        wdata = (mode == 1) ? 32'd0 : $urandom;

        cmd_valid = 1'b1;
        cmd_word  = w;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_word  = $urandom;

        for (int n = 1; n <= 600 && done_n == 0; n++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 4) != 0;
                3:       v = n[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            wr_valid = v;
            wr_data  = wdata;
            rd_ready = v;
            @(negedge clk);
            if (n == 1) check("first_cycle_operation", ctl_operation, first_op);
            if (ctl_operation[3:0] > 4'd3) bad_op++;
            if (opc == 4'd1 && ctl_operation == w && ctl_enable) mm_en++;
            if (wr_ready) begin
                if (ctl_enable !== wr_valid) mirror_bad++;
                if (wr_valid) begin
                    got.push_back(ctl_in_data);
                    exp_q.push_back(wr_data);
                    hs++;
                    if (hs == PAGE_WORDS) last_hs = n;
                    wdata = (mode == 1) ? 32'(hs) : $urandom;
                end
            end
            if (opc == 4'd3 && ctl_operation == w) begin
                if (ctl_enable !== rd_ready) mirror_bad++;
                if (ctl_enable) begin
                    en_rd++;
                    if (en_rd == PAGE_WORDS + RD_LAT) last_en = n;
                end
            end
            if (rd_valid) begin
                if (!rd_ready) mirror_bad++;
                else begin
                    got.push_back(rd_data);
                    words++;
                end
            end
            if (done) done_n = n;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        case (opc)
            4'd1:    exp_done = MM_CYCLES + 1;
            4'd2:    exp_done = last_hs + 1;
            4'd3:    exp_done = last_en + 1;
            default: exp_done = 1;
        endcase
        if (done_n == 0) $display("FAIL done_timeout: cmd 0x%08h never completed", w);
        check("done_cycle", 32'(done_n), 32'(exp_done));
        check("illegal_opcode_cycles", 32'(bad_op), 32'd0);
        check("enable_handshake_mirror", 32'(mirror_bad), 32'd0);
        check("err_flag", 32'(err), 32'(exp_err));
        if (opc == 4'd1) begin
            check("mm_enabled_cycles", 32'(mm_en), 32'(MM_CYCLES));
        end else if (opc == 4'd2) begin
            check("wr_handshakes", 32'(hs), 32'(PAGE_WORDS));
        end else if (opc == 4'd3) begin
            for (int k = 1; k <= PAGE_WORDS; k++) exp_q.push_back(32'(k) ^ salt);
            check("rd_words", 32'(words), 32'(PAGE_WORDS));
        end else begin
            check("noop_transfers", 32'(hs + words + mm_en), 32'd0);
        end
        if (opc == 4'd2 || opc == 4'd3) begin
            if (got.size() != exp_q.size()) seq_bad = 1 + PAGE_WORDS;
            else foreach (got[i]) if (got[i] !== exp_q[i]) seq_bad++;
            check("data_sequence_mismatches", 32'(seq_bad), 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          mode;
        logic [31:0] first_op;
        logic        err_after;
    } vec_t;

    vec_t tbl[9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tbl[0] = '{32'h0000_1041, 0, 32'h0000_1041, 1'b0};
        tbl[1] = '{32'h0000_0052, 1, 32'h0000_0052, 1'b0};
        tbl[2] = '{32'h0000_0053, 3, 32'h0000_0053, 1'b0};
        tbl[3] = '{32'h0000_0000, 0, 32'h0000_0000, 1'b0};
        tbl[4] = '{32'h0000_0007, 0, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h0000_1041, 0, 32'h0000_1041, 1'b1};
        tbl[6] = '{32'h0000_000F, 2, 32'h0000_0000, 1'b1};
        tbl[7] = '{32'h0123_4563, 0, 32'h0123_4563, 1'b1};
        tbl[8] = '{32'h0000_0052, 2, 32'h0000_0052, 1'b1};

        // Reset values while reset is held
        salt = 32'hA5A5_0000;
        repeat (2) @(negedge clk);
        check("rst_ctl_enable", 32'(ctl_enable), 32'd0);
        check("rst_ctl_operation", ctl_operation, 32'd0);
        check("rst_ctl_in_data", ctl_in_data, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data_passthrough", rd_data, 32'hA5A5_0000);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_idle_enable", 32'(ctl_enable), 32'd1);
        salt = '0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 9; i++) run_cmd(tbl[i].word, tbl[i].mode, tbl[i].first_op, tbl[i].err_after);

        // Reset 30 cycles into an MM command
        begin : mid_reset
            int dn;
            dn = 0;
            cmd_valid = 1'b1;
            cmd_word  = 32'h0000_1041;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (done) dn++;
                @(posedge clk); #1;
            end
            check("mm_active_before_reset", ctl_operation, 32'h0000_1041);
            #2 reset = 1'b0;
            #1;
            check("async_rst_busy", 32'(busy), 32'd0);
            check("async_rst_enable", 32'(ctl_enable), 32'd0);
            check("async_rst_operation", ctl_operation, 32'd0);
            check("async_rst_err_cleared", 32'(err), 32'd0);
            @(negedge clk);
            if (done) dn++;
            @(posedge clk); #3;
            reset = 1'b1;
            @(negedge clk);
            if (done) dn++;
            check("abort_no_done", 32'(dn), 32'd0);
            @(posedge clk); #1;
            run_cmd(32'h0000_0041, 0, 32'h0000_0041, 1'b0);
        end

        // Back-to-back MM commands with cmd_valid held high; word changes while busy
        begin : back_to_back
            int h1, h2, c1, c2, zeros, dones;
            h1 = 0; h2 = 0; c1 = 0; c2 = 0; zeros = 0; dones = 0;
            cmd_valid = 1'b1;
            cmd_word  = 32'h0000_1041;
            for (int n = 1; n <= 400 && dones < 2; n++) begin
                @(negedge clk);
                if (ctl_enable && ctl_operation == 32'h0000_1041) c1++;
                if (ctl_enable && ctl_operation == 32'h0000_9991) c2++;
                if (ctl_operation == 32'd0 && c1 > 0 && c2 == 0) zeros++;
                if (done) dones++;
                if (cmd_valid && cmd_ready) begin
                    if (h1 == 0) h1 = n;
                    else         h2 = n;
                end
                @(posedge clk); #1;
                if (h1 != 0 && h2 == 0) cmd_word = 32'h0000_9991;
                if (h2 != 0) cmd_valid = 1'b0;
            end
            cmd_valid = 1'b0;
            check("b2b_accept_spacing", 32'(h2 - h1), 32'(MM_CYCLES + 2));
            check("b2b_first_word_held", 32'(c1), 32'(MM_CYCLES));
            check("b2b_second_word", 32'(c2), 32'(MM_CYCLES));
            check("b2b_zero_gap_cycles", 32'(zeros), 32'd2);
            check("b2b_done_pulses", 32'(dones), 32'd2);
        end

        // Random commands against the transaction-level rules
        begin : random_cmds
            logic        err_m;
            logic [31:0] w;
            logic [3:0]  opc;
            int          r;
            err_m = 1'b0;
            for (int i = 0; i < 12; i++) begin
                r = $urandom_range(0, 9);
                if (r < 2)       opc = 4'd1;
                else if (r < 4)  opc = 4'd2;
                else if (r < 7)  opc = 4'd3;
                else if (r == 7) opc = 4'd0;
                else             opc = 4'($urandom_range(4, 15));
                w = $urandom;
                w[3:0] = opc;
                if (opc > 4'd3) err_m = 1'b1;
                salt = $urandom;
                run_cmd(w, int'($urandom_range(0, 3)),
                        (opc >= 4'd1 && opc <= 4'd3) ? w : 32'd0, err_m);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
